// File: rtl/scanline_if.sv
// Scanline write bus between a line renderer (master) and the line reader (slave).
// The reader returns line/frame timing strobes to the renderer.
interface scanline_if;
    logic [10:0] sladdr;
    logic [7:0]  rdata;
    logic [7:0]  gdata;
    logic [7:0]  bdata;
    logic        slwe_r;
    logic        slwe_g;
    logic        slwe_b;
    logic        linesync;
    logic        framesync;

    modport master (
        output sladdr, rdata, gdata, bdata, slwe_r, slwe_g, slwe_b,
        input  linesync, framesync
    );

    modport slave (
        input  sladdr, rdata, gdata, bdata, slwe_r, slwe_g, slwe_b,
        output linesync, framesync
    );
endinterface

// File: rtl/scanline_reader.sv
// Double-buffered line RAM fed by a line renderer, with raster timing generation and
// registered pixel playback of the previously written line.
module scanline_reader #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_TOTAL  = 1650,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_TOTAL  = 750,
    parameter int unsigned LS_WIDTH = 16,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    scanline_if.slave  sl,
    output logic [7:0] pix_r,
    output logic [7:0] pix_g,
    output logic [7:0] pix_b,
    output logic       pix_de,
    output logic       pix_hs,
    output logic       pix_vs,
    output logic       underrun
);
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic [31:0]   h32, v32;
    logic          last_h, last_v, swap;
    logic          wbank_q, wbank_cur, rbank;
    logic          accept;
    logic [10:0]   wcount_q, wcount_d;
    logic          underrun_d;
    logic [11:0]   waddr, raddr;
    logic          de_cur, hs_cur, vs_cur, ls_cur;

    logic [7:0]    mem_r [4096];
    logic [7:0]    mem_g [4096];
    logic [7:0]    mem_b [4096];
    logic [7:0]    rd_r, rd_g, rd_b;

    logic          de1_q, hs1_q, vs1_q;
    logic          linesync_q, framesync_q, underrun_q;

    always_comb begin
        h32      = 32'(hcount_q);
        v32      = 32'(vcount_q);
        last_h   = (h32 == H_TOTAL - 1);
        last_v   = (v32 == V_TOTAL - 1);
        hcount_d = last_h ? '0 : hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (last_h) begin
            vcount_d = last_v ? '0 : vcount_q + 1'b1;
        end

        // Writes in the swap cycle already land in the new bank; reads use the just-filled one.
        swap      = (hcount_q == '0);
        wbank_cur = wbank_q ^ swap;
        rbank     = ~wbank_cur;

        accept = (sl.slwe_r || sl.slwe_g || sl.slwe_b) && ({1'b0, sl.sladdr} < 12'(H_ACTIVE));

        wcount_d = swap ? '0 : wcount_q;
        if (accept && (wcount_d != 11'h7ff)) begin
            wcount_d = wcount_d + 1'b1;
        end
        // Evaluated on the last cycle so the pulse lines up with the hcount==0 swap cycle.
        underrun_d = last_h && ({1'b0, wcount_d} < 12'(H_ACTIVE));

        waddr = {wbank_cur, sl.sladdr};
        raddr = {rbank, 11'(hcount_q)};

        de_cur = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        hs_cur = ((h32 >= HS_START) && (h32 < HS_END)) ? HS_POL : ~HS_POL;
        vs_cur = ((v32 >= VS_START) && (v32 < VS_END)) ? VS_POL : ~VS_POL;
        ls_cur = (h32 >= H_TOTAL - LS_WIDTH);
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I && accept) begin
            if (sl.slwe_r) mem_r[waddr] <= sl.rdata;
            if (sl.slwe_g) mem_g[waddr] <= sl.gdata;
            if (sl.slwe_b) mem_b[waddr] <= sl.bdata;
        end
        rd_r <= mem_r[raddr];
        rd_g <= mem_g[raddr];
        rd_b <= mem_b[raddr];
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            hcount_q    <= '0;
            vcount_q    <= '0;
            wbank_q     <= 1'b0;
            wcount_q    <= '0;
            de1_q       <= 1'b0;
            hs1_q       <= ~HS_POL;
            vs1_q       <= ~VS_POL;
            linesync_q  <= 1'b0;
            framesync_q <= 1'b0;
            underrun_q  <= 1'b0;
            pix_r       <= 8'h00;
            pix_g       <= 8'h00;
            pix_b       <= 8'h00;
            pix_de      <= 1'b0;
            pix_hs      <= ~HS_POL;
            pix_vs      <= ~VS_POL;
        end else begin
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            wbank_q     <= wbank_cur;
            wcount_q    <= wcount_d;
            de1_q       <= de_cur;
            hs1_q       <= hs_cur;
            vs1_q       <= vs_cur;
            linesync_q  <= ls_cur;
            framesync_q <= last_v;
            underrun_q  <= underrun_d;
            pix_r       <= de1_q ? rd_r : 8'h00;
            pix_g       <= de1_q ? rd_g : 8'h00;
            pix_b       <= de1_q ? rd_b : 8'h00;
            pix_de      <= de1_q;
            pix_hs      <= hs1_q;
            pix_vs      <= vs1_q;
        end
    end

    assign sl.linesync  = linesync_q;
    assign sl.framesync = framesync_q;
    assign underrun     = underrun_q;
endmodule

// File: tb/tb_scanline_reader.sv
// Bench for scanline_reader with a shrunken raster; a position-based model predicts every output.
module tb_scanline_reader;
    localparam int HA = 16, HFP = 2, HSY = 3, HT = 26;
    localparam int VA = 12, VFP = 1, VSY = 2, VT = 16;
    localparam int LS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix_r, pix_g, pix_b;
    logic       pix_de, pix_hs, pix_vs, underrun;

    scanline_if sl ();

    scanline_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_TOTAL(VT),
        .LS_WIDTH(LS), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .CLK_I(clk), .RST_I(rst), .sl(sl),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: two line banks, position counted in cycles since the last reset.
    logic [7:0]  mr [2][2048];
    logic [7:0]  mg [2][2048];
    logic [7:0]  mb [2][2048];
    bit          kr [2][2048];
    bit          kg [2][2048];
    bit          kb [2][2048];
    int          pos = 0;
    bit          mv = 1'b0;
    int          line_cnt = 0;
    int          cur, ln, h, v, wb;
    bit          acc;
    logic        s_de, s_hs, s_vs;
    logic [23:0] s_rgb;
    logic [2:0]  s_kn;
    logic        e_de, e_hs, e_vs, e_ls, e_fs, e_ur;
    logic [23:0] e_rgb;
    logic [2:0]  e_kn;

    always @(posedge clk) begin
        if (rst) begin
            pos = 0; mv = 1'b1; line_cnt = 0;
            s_de = 0; s_hs = 0; s_vs = 0; s_rgb = '0; s_kn = 3'b111;
            e_de = 0; e_hs = 0; e_vs = 0; e_ls = 0; e_fs = 0; e_ur = 0;
            e_rgb = '0; e_kn = 3'b111;
        end else begin
            cur = pos; ln = cur / HT; h = cur % HT; v = ln % VT;
            e_de = s_de; e_hs = s_hs; e_vs = s_vs; e_rgb = s_rgb; e_kn = s_kn;
            s_de = (h < HA) && (v < VA);
            s_hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
            s_vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
            if (s_de) begin
                s_rgb = {mr[ln%2][h], mg[ln%2][h], mb[ln%2][h]};
                s_kn  = {kr[ln%2][h], kg[ln%2][h], kb[ln%2][h]};
            end else begin
                s_rgb = '0; s_kn = 3'b111;
            end
            e_ls = (h >= HT - LS);
            e_fs = (v == VT - 1);
            if (h == 0) line_cnt = 0;
            acc = (sl.slwe_r || sl.slwe_g || sl.slwe_b) && (int'(sl.sladdr) < HA);
            if (acc) begin
                wb = (ln + 1) % 2;
                if (sl.slwe_r) begin mr[wb][sl.sladdr] = sl.rdata; kr[wb][sl.sladdr] = 1'b1; end
                if (sl.slwe_g) begin mg[wb][sl.sladdr] = sl.gdata; kg[wb][sl.sladdr] = 1'b1; end
                if (sl.slwe_b) begin mb[wb][sl.sladdr] = sl.bdata; kb[wb][sl.sladdr] = 1'b1; end
                line_cnt++;
            end
            pos = cur + 1;
            e_ur = (pos % HT == 0) && (line_cnt < HA);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s pos=%0d got=%0h expected=%0h", name, pos, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mv) begin
            chk("pix_de", 32'(pix_de), 32'(e_de));
            chk("pix_hs", 32'(pix_hs), 32'(e_hs));
            chk("pix_vs", 32'(pix_vs), 32'(e_vs));
            chk("linesync", 32'(sl.linesync), 32'(e_ls));
            chk("framesync", 32'(sl.framesync), 32'(e_fs));
            chk("underrun", 32'(underrun), 32'(e_ur));
            if (e_kn[2]) chk("pix_r", 32'(pix_r), 32'(e_rgb[23:16]));
            if (e_kn[1]) chk("pix_g", 32'(pix_g), 32'(e_rgb[15:8]));
            if (e_kn[0]) chk("pix_b", 32'(pix_b), 32'(e_rgb[7:0]));
        end
    end

    task automatic goto(input int p);
        int guard = 0;
        while (pos != p) begin
            if (guard > 5000) begin
                checks++; failures++;
                $display("FAIL goto_timeout pos=%0d expected=%0d", pos, p);
                return;
            end
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic put(input logic [10:0] a, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic [2:0] we);
        sl.sladdr = a; sl.rdata = r; sl.gdata = g; sl.bdata = b;
        sl.slwe_r = we[2]; sl.slwe_g = we[1]; sl.slwe_b = we[0];
    endtask

    task automatic drive_line(input int lnum, input int mode);
        goto(lnum * HT);
        for (int c = 0; c < HT; c++) begin
            logic [7:0] cb;
            cb = 8'(c);
            put(11'd0, 8'h00, 8'h00, 8'h00, 3'b000);
            case (mode)
                0: if (c < HA) put(11'(c), cb, ~cb, 8'h5A, 3'b111);
                1: if (c < HA) put(11'(c), cb + 8'h10, 8'h33, 8'h44, 3'b111);
                2: if (c < HA) put(11'(c), 8'hEE, 8'h77, 8'hEE, 3'b010);
                3: if (c < HA) put(11'(c), 8'hC0 + cb, 8'h0F, cb, 3'b111);
                   else if (c == HT - 1) put(11'h7ff, 8'hFF, 8'hFF, 8'hFF, 3'b111);
                   else put(11'(100 + c), 8'hFF, 8'hFF, 8'hFF, 3'b111);
                4: if (c < 20) put(11'(HA + c), 8'hFF, 8'hFF, 8'hFF, 3'b111);
                5: if (c < 10) put(11'(c), 8'hD0 + cb, 8'hD1, 8'hD2, 3'b111);
                default: if (c < HA) put(11'(c), 8'hE0 + cb, cb, 8'hEE, 3'b111);
            endcase
            @(posedge clk); #1;
        end
        put(11'd0, 8'h00, 8'h00, 8'h00, 3'b000);
    endtask

    task automatic lit_pix(input int p, input string name, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b);
        goto(p);
        @(negedge clk);
        chk({name, "_r"}, 32'(pix_r), 32'(r));
        chk({name, "_g"}, 32'(pix_g), 32'(g));
        chk({name, "_b"}, 32'(pix_b), 32'(b));
    endtask

    task automatic lit_bit(input int p, input string name, input int sel, input logic exp);
        logic act;
        goto(p);
        @(negedge clk);
        case (sel)
            0:       act = pix_de;
            1:       act = sl.linesync;
            default: act = underrun;
        endcase
        chk(name, 32'(act), 32'(exp));
    endtask

    initial begin
        int falls, fsn;
        logic prev;
        put(11'd0, 8'h00, 8'h00, 8'h00, 3'b000);
        rst = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("in_reset_outputs", 32'({pix_r, pix_g, pix_b, pix_de, pix_hs, pix_vs, underrun,
                                     sl.linesync, sl.framesync}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_outputs", 32'({pix_r, pix_g, pix_b, pix_de, pix_hs, pix_vs, underrun,
                                       sl.linesync, sl.framesync}), 32'd0);
        lit_bit(1, "de_still_low", 0, 1'b0);
        lit_bit(2, "first_de", 0, 1'b1);
        lit_bit(HT, "linesync_high", 1, 1'b1);
        lit_bit(HT + 1, "linesync_fall", 1, 1'b0);

        drive_line(3, 1);
        drive_line(4, 0);
        lit_pix(5 * HT + 3 + 2, "line5_px3", 8'h03, 8'hFC, 8'h5A);
        lit_pix(6 * HT + 2 + 2, "line6_old", 8'h12, 8'h33, 8'h44);
        drive_line(7, 2);
        lit_pix(8 * HT + 5 + 2, "green_only", 8'h15, 8'h77, 8'h44);

        fork
            begin
                drive_line(9, 3);
                drive_line(10, 4);
                drive_line(11, 5);
                drive_line(12, 6);
            end
            begin
                lit_bit(10 * HT, "no_underrun_full", 2, 1'b0);
                lit_pix(10 * HT + 7 + 2, "spill_px7", 8'hC7, 8'h0F, 8'h07);
                lit_bit(11 * HT, "underrun_empty", 2, 1'b1);
                lit_bit(12 * HT, "underrun_partial", 2, 1'b1);
                lit_bit(12 * HT + 1, "underrun_one_cycle", 2, 1'b0);
                lit_bit(13 * HT, "no_underrun_e", 2, 1'b0);
            end
        join

        goto(16 * HT);
        @(negedge clk);
        prev = sl.linesync;
        falls = 0;
        fsn = 0;
        for (int k = 0; k < 16 * HT; k++) begin
            @(negedge clk);
            if (prev && !sl.linesync) falls++;
            prev = sl.linesync;
            if (sl.framesync) fsn++;
        end
        chk("linesync_falls_per_frame", 32'(falls), 32'(VT));
        chk("framesync_cycles", 32'(fsn), 32'(HT));

        goto(39 * HT + 13);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midline_reset_outputs", 32'({pix_r, pix_g, pix_b, pix_de, pix_hs, pix_vs, underrun,
                                          sl.linesync, sl.framesync}), 32'd0);
        fork
            drive_line(0, 0);
            begin
                lit_bit(2, "de_after_reset", 0, 1'b1);
                lit_bit(HT, "no_underrun_after_reset", 2, 1'b0);
                lit_pix(HT + 4 + 2, "after_reset_px4", 8'h04, 8'hFB, 8'h5A);
                lit_bit(2 * HT, "underrun_line1", 2, 1'b1);
            end
        join
        goto(3 * HT);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog pos=%0d expected=finish", pos);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
